// File: rtl/afifo_pkg.sv
// afifo_pkg
//   Shared declarations for the dual-clock FIFO read-side stream logic.
//   - occ_state_t : skid-buffer occupancy states; the encoding equals the
//                   number of buffered words.
//   - SKID_DEPTH  : number of entries in the skid buffer.
//   - clog2       : ceiling log2 with a minimum result of 1, used to size
//                   the beat counter.
package afifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/afifo_skid_buf2.sv
// afifo_skid_buf2
//   Two-entry register buffer. A pushed word lands at the tail; the head
//   register always drives the output so there is no combinational path
//   from din_i to head_o.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset (empties the buffer, head=0)
//   push_i  : write din_i into the buffer this cycle
//   din_i   : word to write
//   pop_i   : remove the head word (ignored while empty)
//   head_o  : head word
//   valid_o : buffer holds at least one word
//   occ_o   : occupancy state
module afifo_skid_buf2
    import afifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  valid_o,
    output occ_state_t            occ_o
);

    occ_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop     = pop_i && (state_q != OCC_EMPTY);
        case (state_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    head_d  = din_i;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push_i, pop})
                    2'b10: begin
                        tail_d  = din_i;
                        state_d = OCC_TWO;
                    end
                    2'b01: state_d = OCC_EMPTY;
                    // Simultaneous pop and push: the new word replaces the head.
                    2'b11: head_d = din_i;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = din_i;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    assign head_o  = head_q;
    assign valid_o = (state_q != OCC_EMPTY);
    assign occ_o   = state_q;

endmodule

// File: rtl/afifo_stream_reader.sv
// afifo_stream_reader
//   Read-side consumer for the dual-clock FIFO, entirely in the RClk domain.
//   Issues FIFO reads against a two-word credit, captures the registered
//   FIFO data one cycle after each accepted read into a 2-entry skid buffer,
//   and presents it as a valid/ready stream with burst framing.
// Ports:
//   RClk            : read-domain clock, rising edge
//   PresetFull      : asynchronous active-high reset
//   Fifo_Data_in    : FIFO read data, valid the cycle after an accepted read
//   Fifo_Empty_in   : FIFO empty flag (RClk-synchronous)
//   Fifo_ReadEn_out : FIFO read enable (combinational)
//   M_Data_out      : stream data
//   M_Valid_out     : stream valid
//   M_Ready_in      : stream ready
//   M_Last_out      : last word of a BURST_LEN-word burst, qualified by valid
//   Busy_out        : a read is in flight or the buffer is non-empty
//   Word_Count_out  : words delivered, modulo 2^CNT_WIDTH; only present when
//                     AFIFO_STREAM_READER_STATS_EN is defined
module afifo_stream_reader
    import afifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  RClk,
    input  logic                  PresetFull,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic                  Fifo_Empty_in,
    output logic                  Fifo_ReadEn_out,
    output logic [DATA_WIDTH-1:0] M_Data_out,
    output logic                  M_Valid_out,
    input  logic                  M_Ready_in,
    output logic                  M_Last_out,
    output logic                  Busy_out
`ifdef AFIFO_STREAM_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  Word_Count_out
`endif
);

    localparam int unsigned          BEAT_W    = clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("BURST_LEN must be at least 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    logic              inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    occ_state_t        occ;
    logic [1:0]        occ_cnt;
    logic              pop;
    logic [2:0]        used;
    logic              credit_ok;

    afifo_skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i  (RClk),
        .rst_i  (PresetFull),
        .push_i (inflight_q),
        .din_i  (Fifo_Data_in),
        .pop_i  (pop),
        .head_o (M_Data_out),
        .valid_o(M_Valid_out),
        .occ_o  (occ)
    );

    assign pop     = M_Valid_out & M_Ready_in;
    assign occ_cnt = occ;

    // Words held plus the word on its way must stay below SKID_DEPTH; a pop
    // in this cycle returns its slot immediately, which keeps 1 word/cycle.
    assign used      = {1'b0, occ_cnt} + {2'b00, inflight_q};
    assign credit_ok = used < (3'(SKID_DEPTH) + {2'b00, pop});

    assign Fifo_ReadEn_out = !PresetFull && !Fifo_Empty_in && credit_ok;

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

    always_comb begin
        inflight_d = Fifo_ReadEn_out & !Fifo_Empty_in;
        beat_d     = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    assign M_Last_out = M_Valid_out && (beat_q == LAST_BEAT);
    assign Busy_out   = (occ != OCC_EMPTY) | inflight_q;

`ifdef AFIFO_STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        word_count_d = word_count_q;
        if (pop) begin
            word_count_d = word_count_q + CNT_WIDTH'(1);
        end
    end

    assign Word_Count_out = word_count_q;
`else
`endif

endmodule

// File: tb/tb_afifo_stream_reader.sv
// tb_afifo_stream_reader
//   Bench for afifo_stream_reader (DATA_WIDTH=8, BURST_LEN=4, CNT_WIDTH=16).
//   A FIFO model supplies words from src_q; each accepted read pushes the
//   word to exp_q, and every stream handshake pops and compares it.
module tb_afifo_stream_reader;

    logic       RClk = 1'b0;
    logic       PresetFull;
    logic [7:0] Fifo_Data_in;
    logic       Fifo_Empty_in;
    logic       Fifo_ReadEn_out;
    logic [7:0] M_Data_out;
    logic       M_Valid_out;
    logic       M_Ready_in;
    logic       M_Last_out;
    logic       Busy_out;
`ifdef AFIFO_STREAM_READER_STATS_EN
    logic [15:0] Word_Count_out;
`endif

    afifo_stream_reader #(
        .DATA_WIDTH(8),
        .BURST_LEN (4),
        .CNT_WIDTH (16)
    ) dut (
        .RClk           (RClk),
        .PresetFull     (PresetFull),
        .Fifo_Data_in   (Fifo_Data_in),
        .Fifo_Empty_in  (Fifo_Empty_in),
        .Fifo_ReadEn_out(Fifo_ReadEn_out),
        .M_Data_out     (M_Data_out),
        .M_Valid_out    (M_Valid_out),
        .M_Ready_in     (M_Ready_in),
        .M_Last_out     (M_Last_out),
        .Busy_out       (Busy_out)
`ifdef AFIFO_STREAM_READER_STATS_EN
        ,
        .Word_Count_out (Word_Count_out)
`endif
    );

    always #5 RClk = ~RClk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  exp_q[$];
    logic        rd_pending = 1'b0;
    logic [7:0]  pend_data  = '0;
    int          beat_m     = 0;
    int          delivered  = 0;
    int          lasts_seen = 0;
    int unsigned wc_m       = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;
    logic        prev_last  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO data/empty update just after each rising edge.
    always @(posedge RClk) begin
        #1;
        if (rd_pending) begin
            Fifo_Data_in = pend_data;
            rd_pending   = 1'b0;
        end else begin
            Fifo_Data_in = 8'($urandom);
        end
        Fifo_Empty_in = (src_q.size() == 0);
    end

    // Monitor + FIFO read model, sampled mid-cycle.
    always @(negedge RClk) begin
        if (!PresetFull) begin
            if (prev_stall) begin
                check("stall_valid", 32'(M_Valid_out), 32'd1);
                check("stall_data", 32'(M_Data_out), 32'(prev_data));
                check("stall_last", 32'(M_Last_out), 32'(prev_last));
            end
            if (M_Valid_out && M_Ready_in) begin
`ifdef AFIFO_STREAM_READER_STATS_EN
                check("word_count_run", 32'(Word_Count_out), 32'(wc_m[15:0]));
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", M_Data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("data", 32'(M_Data_out), 32'(e));
                    check("last", 32'(M_Last_out), 32'(beat_m == 3));
                end
                beat_m = (beat_m + 1) % 4;
                delivered++;
                if (M_Last_out) lasts_seen++;
                wc_m++;
            end
            prev_stall = M_Valid_out && !M_Ready_in;
            prev_data  = M_Data_out;
            prev_last  = M_Last_out;
            if (Fifo_ReadEn_out && !Fifo_Empty_in && src_q.size() != 0) begin
                pend_data  = src_q.pop_front();
                exp_q.push_back(pend_data);
                rd_pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge RClk);
        #3;
    endtask

    task automatic reset_dut();
        PresetFull = 1'b1;
        M_Ready_in = 1'b0;
        src_q.delete();
        exp_q.delete();
        rd_pending = 1'b0;
        beat_m     = 0;
        delivered  = 0;
        lasts_seen = 0;
        wc_m       = 0;
        prev_stall = 1'b0;
        tick();
        tick();
        PresetFull = 1'b0;
    endtask

    function automatic logic drained();
        return src_q.size() == 0 && exp_q.size() == 0 && !rd_pending
               && !Busy_out && !M_Valid_out;
    endfunction

    task automatic run_ready(input logic [7:0] mask, input int max_cycles);
        logic [7:0] m;
        m = mask;
        for (int i = 0; i < max_cycles; i++) begin
            if (drained()) break;
            M_Ready_in = m[i % 8];
            tick();
        end
        check("drain_timeout", 32'(drained()), 32'd1);
    endtask

    typedef struct {
        int unsigned nwords;
        logic [7:0]  ready_mask;
        int unsigned exp_delivered;
        int unsigned exp_lasts;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int reads;
        vecs[0] = '{4,  8'hFF, 4,  1};
        vecs[1] = '{7,  8'hAA, 7,  1};
        vecs[2] = '{9,  8'h0F, 9,  2};
        vecs[3] = '{12, 8'h6D, 12, 3};
        vecs[4] = '{1,  8'h81, 1,  0};
        vecs[5] = '{16, 8'hFF, 16, 4};

        PresetFull    = 1'b1;
        Fifo_Empty_in = 1'b1;
        Fifo_Data_in  = '0;
        M_Ready_in    = 1'b0;
        tick();
        // Reset values, and no read while reset is held even if FIFO non-empty.
        Fifo_Empty_in = 1'b0;
        #1;
        check("rst_readen", 32'(Fifo_ReadEn_out), 32'd0);
        check("rst_valid", 32'(M_Valid_out), 32'd0);
        check("rst_data", 32'(M_Data_out), 32'd0);
        check("rst_last", 32'(M_Last_out), 32'd0);
        check("rst_busy", 32'(Busy_out), 32'd0);
`ifdef AFIFO_STREAM_READER_STATS_EN
        check("rst_count", 32'(Word_Count_out), 32'd0);
`endif

        // Latency and back-to-back delivery.
        reset_dut();
        M_Ready_in = 1'b1;
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        tick();
        check("lat_readen_c0", 32'(Fifo_ReadEn_out), 32'd1);
        check("lat_valid_c0", 32'(M_Valid_out), 32'd0);
        tick();
        check("lat_valid_c1", 32'(M_Valid_out), 32'd0);
        check("lat_busy_c1", 32'(Busy_out), 32'd1);
        tick();
        check("lat_valid_c2", 32'(M_Valid_out), 32'd1);
        check("lat_data_c2", 32'(M_Data_out), 32'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_valid", 32'(M_Valid_out), 32'd1);
        end
        check("b2b_last_data", 32'(M_Data_out), 32'h44);
        run_ready(8'hFF, 50);
        check("lat_delivered", 32'(delivered), 32'd4);
        check("lat_lasts", 32'(lasts_seen), 32'd1);

        // Backpressure: only two words requested, then reads stop.
        reset_dut();
        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'hA0 + i));
        reads = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Fifo_ReadEn_out && !Fifo_Empty_in) reads++;
        end
        check("stall_reads", 32'(reads), 32'd2);
        check("stall_readen", 32'(Fifo_ReadEn_out), 32'd0);
        check("stall_head", 32'(M_Data_out), 32'hA0);
        check("stall_busy", 32'(Busy_out), 32'd1);
        run_ready(8'hFF, 60);
        check("stall_delivered", 32'(delivered), 32'd6);

        // FIFO runs dry mid-burst; burst position is retained.
        reset_dut();
        src_q.push_back(8'hB1); src_q.push_back(8'hB2);
        run_ready(8'hFF, 40);
        for (int i = 0; i < 3; i++) tick();
        check("gap_valid", 32'(M_Valid_out), 32'd0);
        check("gap_lasts", 32'(lasts_seen), 32'd0);
        src_q.push_back(8'hB3); src_q.push_back(8'hB4); src_q.push_back(8'hB5);
        run_ready(8'hFF, 40);
        check("gap_delivered", 32'(delivered), 32'd5);
        check("gap_lasts_after", 32'(lasts_seen), 32'd1);

        // Random words with random ready.
        reset_dut();
        for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 300; i++) begin
            if (drained()) break;
            M_Ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        check("rand_drain", 32'(drained()), 32'd1);
        check("rand_delivered", 32'(delivered), 32'd10);

        // Asynchronous reset with the buffer full.
        reset_dut();
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hD0 + i));
        for (int i = 0; i < 4; i++) tick();
        check("arst_pre_valid", 32'(M_Valid_out), 32'd1);
        #1;
        PresetFull = 1'b1;
        #1;
        check("arst_valid", 32'(M_Valid_out), 32'd0);
        check("arst_data", 32'(M_Data_out), 32'd0);
        check("arst_last", 32'(M_Last_out), 32'd0);
        check("arst_busy", 32'(Busy_out), 32'd0);
        check("arst_readen", 32'(Fifo_ReadEn_out), 32'd0);
        reset_dut();
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hC1 + i));
        run_ready(8'hFF, 40);
        check("arst_delivered", 32'(delivered), 32'd4);
        check("arst_lasts", 32'(lasts_seen), 32'd1);

        // Table of burst lengths and ready duty patterns.
        for (int v = 0; v < 6; v++) begin
            reset_dut();
            for (int unsigned k = 0; k < vecs[v].nwords; k++) src_q.push_back(8'($urandom));
            run_ready(vecs[v].ready_mask, 400);
            check("vec_delivered", 32'(delivered), 32'(vecs[v].exp_delivered));
            check("vec_lasts", 32'(lasts_seen), 32'(vecs[v].exp_lasts));
        end

`ifdef AFIFO_STREAM_READER_STATS_EN
        reset_dut();
        for (int i = 0; i < 37; i++) src_q.push_back(8'(i));
        run_ready(8'hFF, 200);
        check("word_count_37", 32'(Word_Count_out), 32'd37);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
